// File: rtl/data_mem_sys_if.sv
// data_mem_sys_if: the CPU data-port bus as seen by the data memory subsystem.
//   ram_ce_i   access enable
//   ram_we_i   1 = write, 0 = read
//   ram_addr_i byte address
//   ram_sel_i  byte-lane enables, sel[i] covers bits [8i+7:8i]
//   ram_data_i write data
//   ram_data_o read data, combinational from the slave
// master = CPU side, slave = memory subsystem side.
interface data_mem_sys_if;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [31:0] ram_addr_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;

  modport master (
    output ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
    input  ram_data_o
  );

  modport slave (
    input  ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
    output ram_data_o
  );
endinterface

// File: rtl/data_mem_sys.sv
// data_mem_sys: data-side memory subsystem behind the CPU MEM stage.
// Decodes addr[31:28]: 0 = byte-writable data RAM (aliases above its depth),
// 1 = peripherals (compare timer + GPIO) at offset addr[4:2], else read 0.
// Reads are combinational (MEM stage cannot stall); writes commit on clk.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   bus          data_mem_sys_if.slave (ce/we/addr/sel/wdata in, rdata out)
//   timer_irq_o  level interrupt, MF & IE, from a flop
//   gpio_o       GPIO output register
// Parameters: RAM_AW = log2 of RAM depth in words (<= 25), GPIO_W = 1..32.

// One byte lane of the data RAM: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module data_mem_lane #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module data_mem_sys #(
  parameter int RAM_AW = 12,
  parameter int GPIO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_sys_if.slave     bus,
  output logic              timer_irq_o,
  output logic [GPIO_W-1:0] gpio_o
);
  localparam int NUM_LANES = 4;

  localparam logic [2:0] OFF_TCNT  = 3'd0;
  localparam logic [2:0] OFF_TCMP  = 3'd1;
  localparam logic [2:0] OFF_TCTRL = 3'd2;
  localparam logic [2:0] OFF_TSTAT = 3'd3;
  localparam logic [2:0] OFF_GPIO  = 3'd4;

  // ---------------------------------------------------------------- decode
  logic [3:0]        region;
  logic              in_ram, in_per, wr, per_wr;
  logic [2:0]        off;
  logic [RAM_AW-1:0] widx;

  assign region = bus.ram_addr_i[31:28];
  assign in_ram = (region == 4'h0);
  assign in_per = (region == 4'h1);
  assign wr     = bus.ram_ce_i & bus.ram_we_i;
  // Peripherals only accept full-word writes; partial lanes are dropped.
  assign per_wr = wr & in_per & (bus.ram_sel_i == 4'hF);
  assign off    = bus.ram_addr_i[4:2];
  assign widx   = bus.ram_addr_i[RAM_AW+1:2];

  // Address bits that neither region decodes (RAM aliasing, byte offset).
  logic unused_addr;
  assign unused_addr = ^{bus.ram_addr_i[27:RAM_AW+2], bus.ram_addr_i[1:0]};

  // ------------------------------------------------------------------ RAM
  logic [NUM_LANES-1:0][7:0] ram_rd;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_mem_lane #(.AW(RAM_AW)) u_lane (
      .clk   (clk),
      .we    (wr & in_ram & bus.ram_sel_i[g]),
      .addr  (widx),
      .wdata (bus.ram_data_i[8*g +: 8]),
      .rdata (ram_rd[g])
    );
  end

  // ----------------------------------------------------------- peripherals
  logic [31:0]       tcnt_q, tcnt_d;
  logic [31:0]       tcmp_q, tcmp_d;
  logic [2:0]        ctrl_q, ctrl_d;    // {IE, CLR, EN}
  logic              mf_q, mf_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              irq_q;
  logic              match;

  // Match is judged on the current (pre-write) TCNT with the current EN.
  assign match = ctrl_q[0] & (tcnt_q == tcmp_q);

  always_comb begin
    tcnt_d = tcnt_q;
    tcmp_d = tcmp_q;
    ctrl_d = ctrl_q;
    gpio_d = gpio_q;

    if (ctrl_q[0])
      tcnt_d = (match & ctrl_q[1]) ? 32'd0 : tcnt_q + 32'd1;

    // CPU write overrides increment / match-clear in the same cycle.
    if (per_wr) begin
      case (off)
        OFF_TCNT:  tcnt_d = bus.ram_data_i;
        OFF_TCMP:  tcmp_d = bus.ram_data_i;
        OFF_TCTRL: ctrl_d = bus.ram_data_i[2:0];
        OFF_GPIO:  gpio_d = bus.ram_data_i[GPIO_W-1:0];
        default:   ;
      endcase
    end

    // A new match beats a simultaneous W1C.
    mf_d = match |
           (mf_q & ~(per_wr & (off == OFF_TSTAT) & bus.ram_data_i[0]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
      tcmp_q <= '0;
      ctrl_q <= '0;
      mf_q   <= 1'b0;
      gpio_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      ctrl_q <= ctrl_d;
      mf_q   <= mf_d;
      gpio_q <= gpio_d;
      // Registered copy of MF & IE so the pin is glitch-free yet tracks
      // the flag in the same cycle MF reads 1.
      irq_q  <= mf_d & ctrl_d[2];
    end
  end

  assign timer_irq_o = irq_q;
  assign gpio_o      = gpio_q;

  // -------------------------------------------------------------- read mux
  logic [31:0] per_rd, rdata;

  always_comb begin
    per_rd = '0;
    case (off)
      OFF_TCNT:  per_rd = tcnt_q;
      OFF_TCMP:  per_rd = tcmp_q;
      OFF_TCTRL: per_rd = {29'd0, ctrl_q};
      OFF_TSTAT: per_rd = {31'd0, mf_q};
      OFF_GPIO:  per_rd = 32'(gpio_q);
      default:   per_rd = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (bus.ram_ce_i) begin
      if (in_ram)      rdata = ram_rd;
      else if (in_per) rdata = per_rd;
    end
  end

  assign bus.ram_data_o = rdata;
endmodule

// File: tb/tb_data_mem_sys.sv
module tb_data_mem_sys;
  localparam int RAM_AW = 12;
  localparam int GPIO_W = 16;

  localparam logic [31:0] A_TCNT  = 32'h1000_0000;
  localparam logic [31:0] A_TCMP  = 32'h1000_0004;
  localparam logic [31:0] A_TCTRL = 32'h1000_0008;
  localparam logic [31:0] A_TSTAT = 32'h1000_000C;
  localparam logic [31:0] A_GPIO  = 32'h1000_0010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic timer_irq_o;
  logic [GPIO_W-1:0] gpio_o;

  data_mem_sys_if bus ();

  data_mem_sys #(.RAM_AW(RAM_AW), .GPIO_W(GPIO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .timer_irq_o (timer_irq_o),
    .gpio_o      (gpio_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mchk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------ behavioural reference
  logic [31:0] m_ram [int];
  logic [31:0] m_tcnt, m_tcmp;
  logic        m_en, m_clr, m_ie, m_mf;
  logic [15:0] m_gpio;

  task automatic m_reset();
    m_tcnt = 0; m_tcmp = 0; m_en = 0; m_clr = 0; m_ie = 0; m_mf = 0; m_gpio = 0;
  endtask

  function automatic int m_key(input logic [31:0] a);
    return int'(a[RAM_AW+1:2]);
  endfunction

  function automatic logic [31:0] m_read(input logic ce, input logic [31:0] a);
    if (!ce) return 32'd0;
    if (a[31:28] == 4'h0) return m_ram.exists(m_key(a)) ? m_ram[m_key(a)] : 32'hx;
    if (a[31:28] != 4'h1) return 32'd0;
    case (a[4:2])
      3'd0: return m_tcnt;
      3'd1: return m_tcmp;
      3'd2: return {29'd0, m_ie, m_clr, m_en};
      3'd3: return {31'd0, m_mf};
      3'd4: return {16'd0, m_gpio};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(input logic ce, we, input logic [31:0] a, input logic [3:0] sel,
                        input logic [31:0] d);
    logic hit, pw;
    logic [31:0] nt, w;
    hit = m_en && (m_tcnt == m_tcmp);
    pw  = ce && we && a[31:28] == 4'h1 && sel == 4'hF;
    nt  = !m_en ? m_tcnt : (hit && m_clr) ? 32'd0 : m_tcnt + 1;
    if (pw && a[4:2] == 3'd3 && d[0]) m_mf = 1'b0;
    if (hit) m_mf = 1'b1;
    if (pw) begin
      case (a[4:2])
        3'd0: nt = d;
        3'd1: m_tcmp = d;
        3'd2: {m_ie, m_clr, m_en} = d[2:0];
        3'd4: m_gpio = d[15:0];
        default: ;
      endcase
    end
    m_tcnt = nt;
    if (ce && we && a[31:28] == 4'h0) begin
      w = m_ram.exists(m_key(a)) ? m_ram[m_key(a)] : 32'hx;
      for (int i = 0; i < 4; i++) if (sel[i]) w[8*i +: 8] = d[8*i +: 8];
      m_ram[m_key(a)] = w;
    end
  endtask

  // One bus cycle: drive just after an edge, sample read data mid-cycle,
  // advance the model with the edge, end 1 time unit after the edge.
  task automatic cyc(input logic ce, we, input logic [31:0] a, input logic [3:0] sel,
                     input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp;
    bus.ram_ce_i = ce; bus.ram_we_i = we; bus.ram_addr_i = a;
    bus.ram_sel_i = sel; bus.ram_data_i = d;
    #1;
    rd  = bus.ram_data_o;
    exp = m_read(ce, a);
    if (mchk) chk($sformatf("rand_rd@%h", a), rd, exp);
    m_step(ce, we, a, sel, d);
    @(posedge clk); #1;
    if (mchk) begin
      chk("rand_irq", 32'(timer_irq_o), 32'(m_mf & m_ie));
      chk("rand_gpio", 32'(gpio_o), 32'(m_gpio));
    end
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    cyc(1'b1, 1'b1, a, 4'hF, d, rd);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    cyc(1'b1, 1'b0, a, 4'hF, 32'd0, rd);
    chk(nm, rd, exp);
  endtask

  task automatic idle();
    logic [31:0] rd;
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, rd);
  endtask

  typedef struct {
    logic        ce, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] d;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    tbl[0]  = '{1'b1, 1'b1, 32'h0000_0010, 4'hF,    32'hAABB_CCDD, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_0010, 4'b0100, 32'h1122_3344, 1'b1, 32'hAABB_CCDD};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0010, 4'hF,    32'h0,         1'b1, 32'hAA22_CCDD};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_4010, 4'hF,    32'h0,         1'b1, 32'hAA22_CCDD};
    tbl[4]  = '{1'b1, 1'b0, 32'h2000_0000, 4'hF,    32'h0,         1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h1000_0014, 4'hF,    32'h0000_1234, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h1000_0014, 4'hF,    32'h0,         1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0000_0010, 4'hF,    32'h0,         1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_0010, 4'hF,    32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0010, 4'hF,    32'h0,         1'b1, 32'hAA22_CCDD};
    tbl[10] = '{1'b1, 1'b1, A_GPIO,        4'hF,    32'h0000_BEEF, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, A_GPIO,        4'hF,    32'h0,         1'b1, 32'h0000_BEEF};
    tbl[12] = '{1'b1, 1'b1, A_GPIO,        4'b0011, 32'h0000_1234, 1'b1, 32'h0000_BEEF};
    tbl[13] = '{1'b1, 1'b0, A_GPIO,        4'hF,    32'h0,         1'b1, 32'h0000_BEEF};
    tbl[14] = '{1'b1, 1'b1, A_TCTRL,       4'hF,    32'hFFFF_FFF8, 1'b1, 32'h0};
    tbl[15] = '{1'b1, 1'b0, A_TCTRL,       4'hF,    32'h0,         1'b1, 32'h0};
    tbl[16] = '{1'b1, 1'b1, 32'hF000_0010, 4'h0,    32'h5555_5555, 1'b1, 32'h0};

    bus.ram_ce_i = 0; bus.ram_we_i = 0; bus.ram_addr_i = 0;
    bus.ram_sel_i = 0; bus.ram_data_i = 0;
    m_reset();

    // Reset state
    #3;
    chk("rst_gpio", 32'(gpio_o), 32'h0);
    chk("rst_irq", 32'(timer_irq_o), 32'h0);
    chk("rst_rd_ce0", bus.ram_data_o, 32'h0);
    #9 rst = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_tcnt", A_TCNT, 32'h0);
    rd_chk("rst_tcmp", A_TCMP, 32'h0);
    rd_chk("rst_tctrl", A_TCTRL, 32'h0);
    rd_chk("rst_tstat", A_TSTAT, 32'h0);
    rd_chk("rst_gpio_reg", A_GPIO, 32'h0);

    // Table-driven vectors: RAM lanes, alias, unmapped, ce gating, GPIO sel
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].d, rd);
      if (tbl[i].chk) chk($sformatf("tbl[%0d]", i), rd, tbl[i].exp);
    end
    chk("gpio_partial_pin", 32'(gpio_o), 32'h0000_BEEF);
    // sel=0 write with we=1 does not mask the read word
    begin
      cyc(1'b1, 1'b1, 32'h0000_0010, 4'h0, 32'h0, rd);
      chk("rd_we1_sel0", rd, 32'hAA22_CCDD);
    end

    // Timer match and clear
    wr32(A_TCMP, 32'd5);
    wr32(A_TCTRL, 32'd7);
    wr32(A_TCNT, 32'd0);
    for (int i = 0; i < 7; i++) begin
      rd_chk($sformatf("mc_tcnt%0d", i), A_TCNT, (i == 6) ? 32'd0 : 32'(i));
      if (i == 4) chk("mc_irq_before", 32'(timer_irq_o), 32'd0);
      if (i == 5) chk("mc_irq_after", 32'(timer_irq_o), 32'd1);
    end
    rd_chk("mc_mf", A_TSTAT, 32'd1);
    wr32(A_TSTAT, 32'd1);
    chk("mc_irq_w1c", 32'(timer_irq_o), 32'd0);
    wr32(A_TCTRL, 32'd0);

    // Wrap without clear, IE=0
    wr32(A_TCNT, 32'hFFFF_FFFE);
    wr32(A_TCMP, 32'hFFFF_FFFF);
    wr32(A_TCTRL, 32'd1);
    rd_chk("wr_fffe", A_TCNT, 32'hFFFF_FFFE);
    rd_chk("wr_ffff", A_TCNT, 32'hFFFF_FFFF);
    rd_chk("wr_0", A_TCNT, 32'd0);
    rd_chk("wr_1", A_TCNT, 32'd1);
    rd_chk("wr_mf", A_TSTAT, 32'd1);
    chk("wr_irq", 32'(timer_irq_o), 32'd0);
    wr32(A_TCTRL, 32'd0);
    wr32(A_TSTAT, 32'd1);

    // Collisions: W1C in match cycle, TCNT write in match cycle
    wr32(A_TCMP, 32'd3);
    wr32(A_TCNT, 32'd0);
    wr32(A_TCTRL, 32'd7);
    rd_chk("co_0", A_TCNT, 32'd0);
    rd_chk("co_1", A_TCNT, 32'd1);
    rd_chk("co_2", A_TCNT, 32'd2);
    wr32(A_TSTAT, 32'd1);
    chk("co_w1c_irq", 32'(timer_irq_o), 32'd1);
    rd_chk("co_w1c_mf", A_TSTAT, 32'd1);
    rd_chk("co_a1", A_TCNT, 32'd1);
    rd_chk("co_a2", A_TCNT, 32'd2);
    wr32(A_TCNT, 32'd100);
    rd_chk("co_tcnt100", A_TCNT, 32'd100);
    wr32(A_TCTRL, 32'd0);
    wr32(A_TSTAT, 32'd1);

    // Async reset mid-count
    wr32(A_TCNT, 32'd0);
    wr32(A_TCMP, 32'd2);
    wr32(A_GPIO, 32'h0000_BEEF);
    wr32(A_TCTRL, 32'd7);
    idle(); idle(); idle(); idle();
    chk("ar_irq_pre", 32'(timer_irq_o), 32'd1);
    chk("ar_gpio_pre", 32'(gpio_o), 32'h0000_BEEF);
    bus.ram_ce_i = 1; bus.ram_we_i = 0; bus.ram_addr_i = A_TCNT;
    bus.ram_sel_i = 4'hF; bus.ram_data_i = 0;
    #1 chk("ar_tcnt_pre", bus.ram_data_o, 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_gpio", 32'(gpio_o), 32'h0);
    chk("ar_irq", 32'(timer_irq_o), 32'h0);
    chk("ar_tcnt", bus.ram_data_o, 32'h0);
    #1 rst = 1'b1;
    m_reset();
    @(posedge clk); #1;
    rd_chk("ar_tctrl_after", A_TCTRL, 32'h0);
    rd_chk("ar_ram_kept", 32'h0000_0010, 32'hAA22_CCDD);

    // Fill a RAM window, then randomized traffic against the model
    for (int i = 0; i < 16; i++) wr32(32'h100 + 32'(i * 4), $urandom);
    mchk = 1'b1;
    for (int n = 0; n < 800; n++) begin
      logic ce, we;
      logic [31:0] a, d;
      logic [3:0] sel;
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)
        a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) << 14);
      else if (r < 9)
        a = 32'h1000_0000 | 32'($urandom_range(0, 7) << 2);
      else
        a = {4'($urandom_range(2, 15)), 28'($urandom)};
      ce  = ($urandom_range(0, 7) != 0);
      we  = $urandom_range(0, 1) == 1;
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      d   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom;
      cyc(ce, we, a, sel, d, rd);
    end
    mchk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_sys.md
# data_mem_sys

Data-side memory subsystem that sits directly downstream of the `cpu` data port and serves its MEM stage. It decodes each access into one of two regions: a byte-writable data RAM, or a small peripheral block containing a compare timer and a GPIO output register. Reads return combinationally in the same cycle, because the MEM stage has no stall path. All writes commit on the rising clock edge.

## Interface
Parameters:
- `RAM_AW`, default 12: RAM depth is 2^RAM_AW 32-bit words, indexed by `ram_addr_i[RAM_AW+1:2]`.
- `GPIO_W`, default 16: width of `gpio_o`, 1..32.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ram_ce_i`  in  1  access enable; no read or write takes effect when 0.
- `ram_we_i`  in  1  1 = write, 0 = read.
- `ram_addr_i`  in  32  byte address; bits [1:0] ignored.
- `ram_sel_i`  in  4  byte-lane enables; `sel[i]` covers data bits [8i+7:8i].
- `ram_data_i`  in  32  write data.
- `ram_data_o`  out  32  read data, combinational.
- `timer_irq_o`  out  1  timer interrupt, level.
- `gpio_o`  out  GPIO_W  GPIO output register.

## Operation
Address decode uses `ram_addr_i[31:28]`:
- 4'h0: data RAM. Addresses above the RAM depth alias, i.e. the upper bits are ignored.
- 4'h1: peripherals, selected by offset `ram_addr_i[4:2]`.
- Any other value: reads return 0 and writes are ignored.

RAM:
- Write when `ce & we`. Only the byte lanes with `sel[i]`=1 are updated.
- Read data is the full word, asynchronous. The `sel` field does not mask read data; the MEM stage extracts bytes itself.
- RAM contents are not reset.

Peripheral registers (offset : name : behaviour):
- 0x00 `TCNT`: 32-bit counter, R/W.
- 0x04 `TCMP`: 32-bit compare value, R/W.
- 0x08 `TCTRL`:
  - bit0 `EN`: counter runs.
  - bit1 `CLR`: counter clears on match.
  - bit2 `IE`: interrupt enable.
  - Bits [31:3] read 0.
- 0x0C `TSTAT`: bit0 `MF` (match flag). Reads return the flag. Writing 1 to bit0 clears it (W1C); writing 0 has no effect.
- 0x10 `GPIO`: bits [GPIO_W-1:0] R/W. Upper bits read 0.
- Offsets 0x14 to 0x1C: read 0, writes ignored.

Peripheral writes:
- Take effect only when `ram_sel_i == 4'b1111`.
- Partial-lane writes to the peripheral region are ignored.

Timer, per cycle with `EN`=1:
- Match is defined as `TCNT == TCMP`.
- On match: `MF` sets. The next `TCNT` is 0 if `CLR`=1, otherwise `TCNT+1`.
- Without a match: `TCNT <= TCNT+1`. The counter wraps from 0xFFFFFFFF to 0.
- With `EN`=0: `TCNT` holds and no match is evaluated.

Outputs:
- `timer_irq_o = MF & IE`, driven from flops and free of glitches.
- `gpio_o` equals the `GPIO` register.

Read mux:
- `ram_data_o` = 0 when `ram_ce_i`=0.
- Otherwise it is the decoded region/register value.
- `ram_we_i` does not gate read data.

## Timing
- Reset (`rst`=0, asynchronous):
  - `TCNT`, `TCMP`, `TCTRL`, `MF` and `GPIO` all go to 0.
  - `timer_irq_o`=0 and `gpio_o`=0.
  - `ram_data_o` is 0 while `ce`=0.
  - Reset asserted mid-count zeroes the timer immediately.
- Read latency: 0 cycles, combinational from address to data.
- Write latency: visible on the cycle after the edge.
- Read-during-write to the same address returns the old value in that cycle and the new value after the edge.
- CPU write to `TCNT` in the same cycle as increment or match-clear: the CPU value wins. Match is still evaluated on the pre-write `TCNT` and may set `MF`.
- W1C to `TSTAT` in the same cycle as a new match: the set wins, and `MF` stays 1.
- CPU write to `TCTRL` takes effect from the next cycle. The counting action in the write cycle uses the old `EN`/`CLR`.
- `timer_irq_o` rises one cycle after the match cycle, i.e. in the same cycle `MF` reads 1.
- `TCMP`=0 with `CLR`=1: a match occurs every cycle and `TCNT` stays 0.

## Test plan
- **RAM byte lanes:**
  - Write 0xAABBCCDD to 0x0000_0010 with sel 1111, then write 0x11223344 with sel 0100.
  - Read 0x10 → 0xAA22CCDD.
  - Read 0x0000_4010 with RAM_AW=12 → same value (alias).
- **Unmapped and ce gating:**
  - Read 0x2000_0000 → 0.
  - Write 0x1234 to 0x1000_0014 → a read there returns 0.
  - With `ce`=0, `ram_data_o`=0 regardless of address.
- **Timer match and clear:**
  - Sequence: TCMP=5, TCTRL=0b111, TCNT=0.
  - TCNT runs 0..5 then returns to 0.
  - MF=1 and `timer_irq_o`=1 one cycle after TCNT==5.
  - W1C TSTAT → irq drops the next cycle.
- **Wrap and non-clear:**
  - Sequence: TCNT=0xFFFFFFFE, TCMP=0xFFFFFFFF, TCTRL=0b001.
  - Counter reads FFFFFFFF, then 0, then 1.
  - MF=1; `timer_irq_o` stays 0 (IE=0).
- **Collisions:**
  - W1C TSTAT in the exact match cycle → MF remains 1.
  - Write TCNT=100 in a match cycle with CLR=1 → TCNT=100 next cycle.
  - Partial-sel write to GPIO → `gpio_o` unchanged.
- **Async reset mid-count:**
  - Set GPIO=0xBEEF and start the timer, then pulse `rst` low between clock edges.
  - `gpio_o`, `timer_irq_o` and TCNT are 0 immediately, before the next edge.
